// File: rtl/cam_dvp_tx_pkg.sv
// Shared camera definitions: pixel format, FSM encoding, pattern codes and
// the default OV7670 VGA geometry.
package cam_dvp_tx_pkg;

  // RGB444 over DVP: byte 0 = {4'h0, R}, byte 1 = {G, B}
  localparam logic [3:0]  PixByte0Hi    = 4'h0;
  localparam int unsigned BytesPerPixel = 2;

  typedef enum logic [2:0] {
    StIdle,
    StVsync,
    StVback,
    StActive,
    StVfront
  } cam_state_e;

  localparam logic [1:0] PatBars    = 2'd0;
  localparam logic [1:0] PatRamp    = 2'd1;
  localparam logic [1:0] PatChecker = 2'd2;
  localparam logic [1:0] PatCount   = 2'd3;

  localparam int unsigned DefHActive    = 640;
  localparam int unsigned DefHBlank     = 288;
  localparam int unsigned DefVsyncLines = 3;
  localparam int unsigned DefVBack      = 17;
  localparam int unsigned DefVActive    = 480;
  localparam int unsigned DefVFront     = 10;

endpackage

// File: rtl/cam_pattern_gen.sv
// Combinational test-pattern source: (x, y, pattern, frame count) -> RGB444.
module cam_pattern_gen
  import cam_dvp_tx_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DefHActive
) (
  input  logic [15:0] x,
  input  logic [3:0]  y,
  input  logic [1:0]  pattern,
  input  logic [3:0]  fc,
  output logic [11:0] rgb
);

  localparam int unsigned BarWidth = H_ACTIVE / 8;

  logic [2:0] bar;
  logic [3:0] chk;
  logic       unused_y;

  assign bar      = 3'(32'(x) / BarWidth);
  assign chk      = {4{x[3] ^ y[3]}};
  assign unused_y = ^y[2:0];

  // Select the colour for the current pixel
  always_comb begin
    rgb = '0;
    case (pattern)
      PatBars:    rgb = {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
      PatRamp:    rgb = {x[3:0], x[3:0], x[3:0]};
      PatChecker: rgb = {chk, chk, chk};
      PatCount:   rgb = {fc, fc, fc};
      default:    rgb = '0;
    endcase
  end

endmodule

// File: rtl/cam_dvp_tx.sv
// OV7670-style DVP transmitter: frame/line timing FSM with registered
// vsync/href/data outputs driven by a deterministic pattern generator.
module cam_dvp_tx
  import cam_dvp_tx_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = DefHActive,
  parameter int unsigned H_BLANK     = DefHBlank,
  parameter int unsigned VSYNC_LINES = DefVsyncLines,
  parameter int unsigned V_BACK      = DefVBack,
  parameter int unsigned V_ACTIVE    = DefVActive,
  parameter int unsigned V_FRONT     = DefVFront
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  output logic        cam_vsynk,
  output logic        cam_href,
  output logic [7:0]  cam_data,
  output logic [15:0] frame_count,
  output logic        frame_done
);

  localparam int unsigned LineLen = BytesPerPixel * H_ACTIVE + H_BLANK;
  localparam int unsigned HW      = $clog2(LineLen + 1);
  localparam int unsigned VMax01  = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
  localparam int unsigned VMax23  = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int unsigned VMax    = (VMax01 > VMax23) ? VMax01 : VMax23;
  localparam int unsigned VW      = $clog2(VMax + 1);

  localparam logic [HW-1:0] HcntLast   = HW'(LineLen - 1);
  localparam logic [HW-1:0] ActBytes   = HW'(BytesPerPixel * H_ACTIVE);
  localparam logic [VW-1:0] VsyncLast  = VW'(VSYNC_LINES - 1);
  localparam logic [VW-1:0] VbackLast  = VW'(V_BACK - 1);
  localparam logic [VW-1:0] ActiveLast = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] VfrontLast = VW'(V_FRONT - 1);
  localparam bit            HasVback   = (V_BACK != 0);
  localparam bit            HasVfront  = (V_FRONT != 0);

  cam_state_e    state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic [1:0]    pat_q, pat_d;
  logic [3:0]    fcl_q, fcl_d;
  logic [15:0]   frame_count_q, frame_count_d;
  logic          vsynk_q, vsynk_d;
  logic          href_q, href_d;
  logic [7:0]    data_q, data_d;
  logic          done_q, done_d;
  logic          line_end, frame_end;
  logic [11:0]   rgb;

  assign line_end = (hcnt_q == HcntLast);

  // Next-state: line/frame sequencing, pattern and frame-count latching
  always_comb begin
    state_d       = state_q;
    hcnt_d        = hcnt_q;
    vcnt_d        = vcnt_q;
    pat_d         = pat_q;
    fcl_d         = fcl_q;
    frame_count_d = frame_count_q;
    frame_end     = 1'b0;
    if (state_q != StIdle) begin
      hcnt_d = line_end ? '0 : hcnt_q + 1'b1;
    end
    case (state_q)
      StIdle: begin
        if (enable) begin
          state_d = StVsync;
          hcnt_d  = '0;
          vcnt_d  = '0;
          pat_d   = pattern_sel;
          fcl_d   = frame_count_q[3:0];
        end
      end
      StVsync: begin
        if (line_end) begin
          if (vcnt_q == VsyncLast) begin
            vcnt_d  = '0;
            state_d = HasVback ? StVback : StActive;
          end else begin
            vcnt_d = vcnt_q + 1'b1;
          end
        end
      end
      StVback: begin
        if (line_end) begin
          if (vcnt_q == VbackLast) begin
            vcnt_d  = '0;
            state_d = StActive;
          end else begin
            vcnt_d = vcnt_q + 1'b1;
          end
        end
      end
      StActive: begin
        if (line_end) begin
          if (vcnt_q == ActiveLast) begin
            vcnt_d = '0;
            if (HasVfront) state_d = StVfront;
            else           frame_end = 1'b1;
          end else begin
            vcnt_d = vcnt_q + 1'b1;
          end
        end
      end
      StVfront: begin
        if (line_end) begin
          if (vcnt_q == VfrontLast) begin
            vcnt_d    = '0;
            frame_end = 1'b1;
          end else begin
            vcnt_d = vcnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // enable only matters here, so a mid-frame drop always finishes the frame
    if (frame_end) begin
      frame_count_d = frame_count_q + 16'd1;
      if (enable) begin
        state_d = StVsync;
        pat_d   = pattern_sel;
        fcl_d   = frame_count_d[3:0];
      end else begin
        state_d = StIdle;
      end
    end
  end

  cam_pattern_gen #(
    .H_ACTIVE (H_ACTIVE)
  ) u_pattern_gen (
    .x       (16'(hcnt_d >> 1)),
    .y       (4'(vcnt_d)),
    .pattern (pat_d),
    .fc      (fcl_d),
    .rgb     (rgb)
  );

  // Outputs decoded from next state so they line up with the state register
  always_comb begin
    vsynk_d = (state_d == StVsync);
    href_d  = (state_d == StActive) && (hcnt_d < ActBytes);
    data_d  = '0;
    if (href_d) begin
      data_d = hcnt_d[0] ? rgb[7:0] : {PixByte0Hi, rgb[11:8]};
    end
    done_d = (hcnt_d == HcntLast) &&
             (((state_d == StVfront) && (vcnt_d == VfrontLast)) ||
              (!HasVfront && (state_d == StActive) && (vcnt_d == ActiveLast)));
  end

  // State, counters and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      pat_q         <= '0;
      fcl_q         <= '0;
      frame_count_q <= '0;
      vsynk_q       <= 1'b0;
      href_q        <= 1'b0;
      data_q        <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      pat_q         <= pat_d;
      fcl_q         <= fcl_d;
      frame_count_q <= frame_count_d;
      vsynk_q       <= vsynk_d;
      href_q        <= href_d;
      data_q        <= data_d;
      done_q        <= done_d;
    end
  end

  assign cam_vsynk   = vsynk_q;
  assign cam_href    = href_q;
  assign cam_data    = data_q;
  assign frame_count = frame_count_q;
  assign frame_done  = done_q;

endmodule

// File: tb/tb_cam_dvp_tx.sv
// Directed bench for cam_dvp_tx: small geometry (L=20, 100-cycle frame) plus a
// 16x16 instance for the checker pattern. Outputs are sampled on negedges.
module tb_cam_dvp_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic        cam_vsynk, cam_href, frame_done;
  logic [7:0]  cam_data;
  logic [15:0] frame_count;
  logic        vs2, hr2, fd2;
  logic [7:0]  d2;
  logic [15:0] fc2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cam_dvp_tx #(
    .H_ACTIVE(8), .H_BLANK(4), .VSYNC_LINES(1), .V_BACK(1), .V_ACTIVE(2), .V_FRONT(1)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .pattern_sel(pattern_sel),
    .cam_vsynk(cam_vsynk), .cam_href(cam_href), .cam_data(cam_data),
    .frame_count(frame_count), .frame_done(frame_done)
  );

  cam_dvp_tx #(
    .H_ACTIVE(16), .H_BLANK(4), .VSYNC_LINES(1), .V_BACK(1), .V_ACTIVE(16), .V_FRONT(1)
  ) dut2 (
    .clk(clk), .reset(reset), .enable(enable), .pattern_sel(pattern_sel),
    .cam_vsynk(vs2), .cam_href(hr2), .cam_data(d2),
    .frame_count(fc2), .frame_done(fd2)
  );

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    enable = 1'b0;
    pattern_sel = 2'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  // Request a frame; returns at the negedge of frame cycle 0
  task automatic start_frame(input logic [1:0] pat);
    pattern_sel = pat;
    enable = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int cnt;
    @(negedge clk);
    reset = 1'b1;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (cam_vsynk !== 1'b0) begin n_fail++; $display("FAIL rst_vsynk: got %b want 0", cam_vsynk); end
    n_tests++;
    if (cam_href !== 1'b0) begin n_fail++; $display("FAIL rst_href: got %b want 0", cam_href); end
    n_tests++;
    if (cam_data !== 8'h00) begin n_fail++; $display("FAIL rst_data: got %h want 00", cam_data); end
    n_tests++;
    if (frame_count !== 16'h0) begin n_fail++; $display("FAIL rst_fc: got %h want 0000", frame_count); end
    n_tests++;
    if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", frame_done); end
    enable = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (cam_vsynk !== 1'b0) begin n_fail++; $display("FAIL rst_en_vsynk: got %b want 0", cam_vsynk); end
    reset = 1'b0;
    cnt = 0;
    @(negedge clk);
    while (cam_vsynk === 1'b1 && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    n_tests++;
    if (cnt != 20) begin n_fail++; $display("FAIL vsynk_len: got %0d want 20", cnt); end
  endtask

  task automatic test_bars();
    logic [7:0] exp_b [0:15];
    exp_b = '{8'h00, 8'h00, 8'h00, 8'h0F, 8'h00, 8'hF0, 8'h00, 8'hFF,
              8'h0F, 8'h00, 8'h0F, 8'h0F, 8'h0F, 8'hF0, 8'h0F, 8'hFF};
    do_reset();
    start_frame(2'd0);
    repeat (40) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      n_tests++;
      if (cam_href !== (i < 16)) begin
        n_fail++; $display("FAIL bars_href[%0d]: got %b want %b", i, cam_href, (i < 16));
      end
      n_tests++;
      if (i < 16) begin
        if (cam_data !== exp_b[i]) begin
          n_fail++; $display("FAIL bars_data[%0d]: got %h want %h", i, cam_data, exp_b[i]);
        end
      end else if (cam_data !== 8'h00) begin
        n_fail++; $display("FAIL bars_blank[%0d]: got %h want 00", i, cam_data);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_checker();
    // Pixel (x,y) byte 0 sits at cycle 72 + 36*y + 2*x on the 16x16 instance
    int         ck_c [0:7];
    logic [7:0] ck_v [0:7];
    ck_c = '{72, 73, 88, 89, 360, 361, 376, 377};
    ck_v = '{8'h00, 8'h00, 8'h0F, 8'hFF, 8'h0F, 8'hFF, 8'h00, 8'h00};
    do_reset();
    start_frame(2'd2);
    for (int c = 0; c <= 377; c++) begin
      for (int j = 0; j < 8; j++) begin
        if (c == ck_c[j]) begin
          n_tests++;
          if (hr2 !== 1'b1 || d2 !== ck_v[j]) begin
            n_fail++;
            $display("FAIL checker@%0d: got href=%b data=%h want href=1 data=%h",
                     c, hr2, d2, ck_v[j]);
          end
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_enable_drop();
    logic dirty;
    dirty = 1'b0;
    do_reset();
    start_frame(2'd0);
    for (int c = 0; c <= 130; c++) begin
      if (c == 0) begin
        n_tests++;
        if (cam_vsynk !== 1'b1) begin n_fail++; $display("FAIL drop_vs0: got %b want 1", cam_vsynk); end
      end
      if (c == 98) begin
        n_tests++;
        if (frame_done !== 1'b0) begin n_fail++; $display("FAIL drop_done98: got %b want 0", frame_done); end
      end
      if (c == 99) begin
        n_tests++;
        if (frame_done !== 1'b1) begin n_fail++; $display("FAIL drop_done99: got %b want 1", frame_done); end
        n_tests++;
        if (frame_count !== 16'd0) begin n_fail++; $display("FAIL drop_fc99: got %h want 0000", frame_count); end
      end
      if (c == 100) begin
        n_tests++;
        if (frame_count !== 16'd1) begin n_fail++; $display("FAIL drop_fc100: got %h want 0001", frame_count); end
      end
      if (c >= 100 && (cam_vsynk || cam_href || cam_data != 8'h00 || frame_done)) dirty = 1'b1;
      if (c == 50) enable = 1'b0;
      @(negedge clk);
    end
    n_tests++;
    if (dirty !== 1'b0) begin n_fail++; $display("FAIL drop_idle: got activity=%b want 0", dirty); end
  endtask

  task automatic test_count_pattern();
    logic [3:0] k;
    do_reset();
    start_frame(2'd3);
    for (int c = 0; c <= 545; c++) begin
      k = 4'(c / 100);
      if (c < 400 && (c % 100) == 1) begin
        n_tests++;
        if (frame_count !== 16'(k)) begin
          n_fail++; $display("FAIL cnt_fc@%0d: got %h want %h", c, frame_count, 16'(k));
        end
      end
      if (c < 400 && (c % 100) == 40) begin
        n_tests++;
        if (cam_data !== {4'h0, k}) begin
          n_fail++; $display("FAIL cnt_b0@%0d: got %h want %h", c, cam_data, {4'h0, k});
        end
      end
      if (c < 400 && (c % 100) == 41) begin
        n_tests++;
        if (cam_data !== {k, k}) begin
          n_fail++; $display("FAIL cnt_b1@%0d: got %h want %h", c, cam_data, {k, k});
        end
      end
      if (c == 399) begin
        n_tests++;
        if (frame_done !== 1'b1 || frame_count !== 16'hFFFE) begin
          n_fail++; $display("FAIL wrap_399: got done=%b fc=%h want done=1 fc=fffe", frame_done, frame_count);
        end
      end
      if (c == 400) begin
        n_tests++;
        if (frame_count !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_400: got %h want ffff", frame_count); end
      end
      if (c == 440) begin
        n_tests++;
        if (cam_data !== 8'h0F) begin n_fail++; $display("FAIL wrap_b0_f: got %h want 0f", cam_data); end
      end
      if (c == 441) begin
        n_tests++;
        if (cam_data !== 8'hFF) begin n_fail++; $display("FAIL wrap_b1_f: got %h want ff", cam_data); end
      end
      if (c == 500) begin
        n_tests++;
        if (frame_count !== 16'h0000) begin n_fail++; $display("FAIL wrap_500: got %h want 0000", frame_count); end
      end
      if (c == 540) begin
        n_tests++;
        if (cam_data !== 8'h00) begin n_fail++; $display("FAIL wrap_b0_0: got %h want 00", cam_data); end
      end
      if (c == 541) begin
        n_tests++;
        if (cam_data !== 8'h00) begin n_fail++; $display("FAIL wrap_b1_0: got %h want 00", cam_data); end
      end
      if (c == 350) force dut.frame_count_q = 16'hFFFE;
      if (c == 351) release dut.frame_count_q;
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    start_frame(2'd1);
    repeat (44) @(negedge clk);
    n_tests++;
    if (cam_href !== 1'b1 || cam_data !== 8'h02) begin
      n_fail++; $display("FAIL ramp44: got href=%b data=%h want href=1 data=02", cam_href, cam_data);
    end
    @(negedge clk);
    n_tests++;
    if (cam_data !== 8'h22) begin n_fail++; $display("FAIL ramp45: got %h want 22", cam_data); end
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if (cam_vsynk !== 1'b0 || cam_href !== 1'b0 || cam_data !== 8'h00) begin
      n_fail++;
      $display("FAIL async_rst: got vs=%b href=%b data=%h want 0/0/00", cam_vsynk, cam_href, cam_data);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n_tests++;
    if (cam_vsynk !== 1'b0) begin n_fail++; $display("FAIL rel_vs0: got %b want 0", cam_vsynk); end
    @(negedge clk);
    n_tests++;
    if (cam_vsynk !== 1'b1) begin n_fail++; $display("FAIL rel_vs1: got %b want 1", cam_vsynk); end
    n_tests++;
    if (frame_count !== 16'd0) begin n_fail++; $display("FAIL rel_fc: got %h want 0000", frame_count); end
  endtask

  initial begin
    test_reset();
    test_bars();
    test_checker();
    test_enable_drop();
    test_count_pattern();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
